hilo_mac_sequencer: RTL and testbench

Multi-cycle sequencer for the HI/LO multiply unit. It accepts mult, multu, madd and msub operations from the decode/execute stage and runs an iterative shift-add multiply. It then accumulates into or overwrites the HI/LO pair and stalls the pipeline on any HI/LO access while an operation is in flight. It replaces the single-cycle multiply path and sits beside the ALU, driven by the controller's hi_write/lo_write/hi_read/lo_read decode.

---
 rtl/hilo_pkg.sv | 24 ++
 rtl/hilo_mac_sequencer_mac_iter_core.sv | 68 ++++++
 rtl/hilo_mac_sequencer.sv | 113 +++++++++++
 tb/tb_hilo_mac_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: op encodings, FSM states
// and the default operand width.
package hilo_pkg;

   localparam int WIDTH_DEFAULT = 32;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_MADD  = 2'b10;
   localparam logic [1:0] OP_MSUB  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_FIX    = 2'b10,
      S_COMMIT = 2'b11
   } state_t;

   // Only multu treats its operands as unsigned.
   function automatic logic op_is_signed(input logic [1:0] op);
      return op != OP_MULTU;
   endfunction

endpackage

// File: rtl/hilo_mac_sequencer_mac_iter_core.sv
// Iterative shift-add multiply core: magnitude registers, product, counter and sign fix-up.
// HILO_EARLY_OUT_EN: stop iterating once the remaining multiplier bits are zero.
module mac_iter_core
   import hilo_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic               fix,
   input  logic [WIDTH-1:0]   mcand_in,
   input  logic [WIDTH-1:0]   mplier_in,
   input  logic               neg_in,
   output logic               last,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic               neg;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     upper_sum;
   logic [2*WIDTH-1:0] step_prod;
   logic [2*WIDTH-1:0] aligned;

   always_comb begin
      upper_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
      step_prod = {upper_sum, prod[WIDTH-1:1]};
`ifdef HILO_EARLY_OUT_EN
      last    = (count == CW'(1)) || (mplier[WIDTH-1:1] == '0);
      // An early exit still owes count-1 right shifts to line the product up.
      aligned = step_prod >> (count - CW'(1));
`else
      last    = (count == CW'(1));
      aligned = step_prod;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         neg    <= 1'b0;
         count  <= '0;
         prod   <= '0;
      end else if (load) begin
         mcand  <= mcand_in;
         mplier <= mplier_in;
         neg    <= neg_in;
         count  <= CW'(WIDTH);
         prod   <= '0;
      end else if (step) begin
         prod   <= last ? aligned : step_prod;
         mplier <= mplier >> 1;
         count  <= count - CW'(1);
      end else if (fix) begin
         prod   <= neg ? -prod : prod;
      end
   end

   assign product = prod;

endmodule

// File: rtl/hilo_mac_sequencer.sv
// HI/LO multiply/accumulate sequencer: FSM, architectural HI/LO, accumulate adder and stall.
// HILO_EARLY_OUT_EN (in mac_iter_core) shortens RUN for small multipliers.
module hilo_mac_sequencer
   import hilo_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             MtHi,
   input  logic             MtLo,
   input  logic [WIDTH-1:0] WData,
   input  logic             MfReq,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             Busy,
   output logic             Stall,
   output logic             Done
);

   state_t             state, state_nx;
   logic [1:0]         op_q;
   logic               load, step, fix, last;
   logic               sgn;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic               neg_in;
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] acc;

   // Magnitudes are plain unsigned values, so the most-negative operand cannot overflow.
   assign sgn    = op_is_signed(Op);
   assign mag_a  = (sgn && A[WIDTH-1]) ? -A : A;
   assign mag_b  = (sgn && B[WIDTH-1]) ? -B : B;
   assign neg_in = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);

   mac_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk       (Clk),
      .rst_n     (Reset_n),
      .load      (load),
      .step      (step),
      .fix       (fix),
      .mcand_in  (mag_a),
      .mplier_in (mag_b),
      .neg_in    (neg_in),
      .last      (last),
      .product   (product)
   );

   always_comb begin
      case (op_q)
         OP_MADD: acc = {Hi, Lo} + product;
         OP_MSUB: acc = {Hi, Lo} - product;
         default: acc = product;
      endcase
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      step     = 1'b0;
      fix      = 1'b0;
      case (state)
         S_IDLE: begin
            if (Start) begin
               load     = 1'b1;
               state_nx = S_RUN;
            end
         end
         S_RUN: begin
            step = 1'b1;
            if (last) state_nx = S_FIX;
         end
         S_FIX: begin
            fix      = 1'b1;
            state_nx = S_COMMIT;
         end
         S_COMMIT: state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= S_IDLE;
         op_q  <= OP_MULT;
      end else begin
         state <= state_nx;
         if (load) op_q <= Op;
      end
   end

   // A Start in the same cycle as mthi/mtlo takes priority and drops the move.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Hi <= '0;
         Lo <= '0;
      end else if (state == S_COMMIT) begin
         {Hi, Lo} <= acc;
      end else if (state == S_IDLE && !Start) begin
         if (MtHi) Hi <= WData;
         if (MtLo) Lo <= WData;
      end
   end

   assign Busy  = (state != S_IDLE);
   assign Done  = (state == S_COMMIT);
   assign Stall = Busy && (Start || MfReq || MtHi || MtLo);

endmodule

// File: tb/tb_hilo_mac_sequencer.sv
// Scoreboard bench for hilo_mac_sequencer: directed ops push expected HI/LO and
// commit cycle; a monitor pops and compares whenever Done is presented.
module tb_hilo_mac_sequencer;
   import hilo_pkg::*;

   localparam int W = 32;

   logic         Clk = 1'b0;
   logic         Reset_n = 1'b0;
   logic         Start = 1'b0;
   logic [1:0]   Op = 2'b00;
   logic [W-1:0] A = '0, B = '0, WData = '0;
   logic         MtHi = 1'b0, MtLo = 1'b0, MfReq = 1'b0;
   logic [W-1:0] Hi, Lo;
   logic         Busy, Stall, Done;

   typedef struct {
      logic [2*W-1:0] hilo;
      int             cyc;
      string          name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   n_ops = 0;

   hilo_mac_sequencer #(.WIDTH(W)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .A(A), .B(B),
      .MtHi(MtHi), .MtLo(MtLo), .WData(WData), .MfReq(MfReq),
      .Hi(Hi), .Lo(Lo), .Busy(Busy), .Stall(Stall), .Done(Done)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Expected RUN length: full width, or highest set bit of |B| (min 1) with early-out.
   function automatic int run_k(input logic [1:0] op, input logic [W-1:0] b);
      logic [W-1:0] m;
      int k;
      m = (op != OP_MULTU && b[W-1]) ? -b : b;
      k = W;
`ifdef HILO_EARLY_OUT_EN
      k = 1;
      for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
`endif
      return k;
   endfunction

   initial begin : monitor
      bit   pend;
      exp_t e;
      pend = 1'b0;
      forever begin
         @(negedge Clk);
         if (pend) begin
            pend = 1'b0;
            if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
            else begin
               e = sb.pop_front();
               chk({e.name, "_hilo"}, {Hi, Lo}, e.hilo);
            end
         end
         if (Done) begin
            done_cnt++;
            pend = 1'b1;
            if (sb.size() > 0) chk({sb[0].name, "_latency"}, 64'(cyc), 64'(sb[0].cyc));
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input string name,
                        input logic mthi, input logic mtlo, input logic [W-1:0] wd);
      exp_t e;
      @(negedge Clk);
      Start = 1'b1; Op = op; A = a; B = b;
      MtHi = mthi; MtLo = mtlo; WData = wd;
      e.hilo = exp;
      e.cyc  = cyc + run_k(op, b) + 2;
      e.name = name;
      sb.push_back(e);
      n_ops++;
      @(negedge Clk);
      Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (Busy && n < 200) begin
         @(negedge Clk);
         n++;
      end
      if (Busy) chk({name, "_timeout"}, 64'd1, 64'd0);
   endtask

   task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input string name);
      issue(op, a, b, exp, name, 1'b0, 1'b0, '0);
      wait_idle(name);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin : stim
      int bad;
      int n;
      repeat (2) @(negedge Clk);
      chk("reset_hilo", {Hi, Lo}, 64'd0);
      chk("reset_ctrl", {61'd0, Busy, Stall, Done}, 64'd0);
      Reset_n = 1'b1;

      do_op(OP_MULT,  32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, "mult_neg");
      do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "multu_max");
      do_op(OP_MULTU, 32'h80000000, 32'd2,        64'h00000001_00000000, "multu_msb");

      @(negedge Clk); MtLo = 1'b1; WData = 32'd5;
      @(negedge Clk); MtLo = 1'b0; MtHi = 1'b1; WData = 32'd0;
      chk("mtlo", {32'd0, Lo}, 64'd5);
      @(negedge Clk); MtHi = 1'b0;
      chk("mthi", {32'd0, Hi}, 64'd0);

      do_op(OP_MADD, 32'd2, 32'd3, 64'h00000000_0000000B, "madd");
      do_op(OP_MSUB, 32'd4, 32'd4, 64'hFFFFFFFF_FFFFFFFB, "msub");
      do_op(OP_MULT, 32'h80000000, 32'h80000000, 64'h40000000_00000000, "mult_minmin");
      do_op(OP_MULT, 32'h80000000, 32'd1,        64'hFFFFFFFF_80000000, "mult_min1");
      do_op(OP_MULT, 32'd0, 32'd12345, 64'd0, "mult_zero");

      // Start wins over a simultaneous mthi: accumulate sees the old HI of zero.
      issue(OP_MADD, 32'd6, 32'd7, 64'd42, "madd_mt_drop", 1'b1, 1'b0, 32'h55);
      chk("mt_dropped", {32'd0, Hi}, 64'd0);
      wait_idle("madd_mt_drop");

      // mflo three cycles after Start stalls until the commit, then reads the new LO.
      issue(OP_MULT, 32'd9, 32'd9, 64'd81, "mult_mf", 1'b0, 1'b0, '0);
      repeat (2) @(negedge Clk);
      MfReq = 1'b1;
      #1 chk("mf_stall", {63'd0, Stall}, 64'd1);
      bad = 0; n = 0;
      while (Busy && n < 200) begin
         @(negedge Clk);
         if (Busy && !Stall) bad++;
         n++;
      end
      chk("mf_stall_held", 64'(bad), 64'd0);
      chk("mf_read", {32'd0, Lo}, 64'd81);
      chk("mf_release", {63'd0, Stall}, 64'd0);
      MfReq = 1'b0;

      // mtlo while busy stalls and is not written.
      issue(OP_MADD, 32'd3, 32'd3, 64'd90, "madd_mt_busy", 1'b0, 1'b0, '0);
      MtLo = 1'b1; WData = 32'h77;
      #1 chk("mt_busy_stall", {63'd0, Stall}, 64'd1);
      @(negedge Clk); MtLo = 1'b0;
      wait_idle("madd_mt_busy");

      // Reset at RUN cycle 10 aborts the operation.
      issue(OP_MULT, 32'd100, 32'd100, 64'd10000, "mult_abort", 1'b0, 1'b0, '0);
      repeat (9) @(negedge Clk);
      void'(sb.pop_back());
      n_ops--;
      Reset_n = 1'b0;
      #1 chk("abort_hilo", {Hi, Lo}, 64'd0);
      chk("abort_ctrl", {61'd0, Busy, Stall, Done}, 64'd0);
      @(negedge Clk); Reset_n = 1'b1;
      do_op(OP_MULT, 32'd6, 32'd7, 64'd42, "mult_after_reset");

      do_op(OP_MULT, 32'd5, 32'd1, 64'd5, "mult_small");

      repeat (3) @(negedge Clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      chk("done_count", 64'(done_cnt), 64'(n_ops));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
